// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a 5-stage ARM pipeline: post-reset front-end hold, load-use
// stalls, taken-branch flushes, operand forwarding selects and saturating event counters.
module pipeline_hazard_controller #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rs,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rs,
  input  logic [3:0]       id_dest,
  input  logic             id_reg_write,
  input  logic             id_load,
  input  logic             ex_branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_mux_select,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       fwd_c_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       ctrl_action
);

  localparam int              HC_W      = (RESET_HOLD_CYCLES < 2) ? 1 : $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(RESET_HOLD_CYCLES);
  localparam logic [3:0]      PC_REG    = 4'd15;

  typedef enum logic { ST_HOLD = 1'b0, ST_RUN = 1'b1 } state_e;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'b00,
    ACT_RUN   = 2'b01,
    ACT_STALL = 2'b10,
    ACT_FLUSH = 2'b11
  } action_e;

  typedef struct packed {
    logic [3:0] tag;
    logic       we;
    logic       ld;
  } shadow_t;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  shadow_t         ex_q, mem_q, wb_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic run_s, load_use_s, flush_s, stall_s;

  // R15 is the PC: never a forwarding source nor a hazard producer.
  // allow_load=0 excludes a load in that stage, which cannot forward yet.
  function automatic logic stage_hit(input shadow_t s, input logic [3:0] src,
                                     input logic used, input logic allow_load);
    return used && s.we && (allow_load || !s.ld) &&
           (s.tag != PC_REG) && (src != PC_REG) && (s.tag == src);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [3:0] src, input logic used,
                                          input shadow_t ex, input shadow_t mem,
                                          input shadow_t wb);
    logic [1:0] sel;
    if (stage_hit(ex, src, used, 1'b0)) begin
      sel = 2'b01;
    end else if (stage_hit(mem, src, used, 1'b1)) begin
      sel = 2'b10;
    end else if (stage_hit(wb, src, used, 1'b1)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Hazard detection and per-cycle control outputs
  always_comb begin
    run_s      = (state_q == ST_RUN);
    load_use_s = ex_q.ld && (stage_hit(ex_q, id_rn, id_use_rn, 1'b1) ||
                             stage_hit(ex_q, id_rm, id_use_rm, 1'b1) ||
                             stage_hit(ex_q, id_rs, id_use_rs, 1'b1));
    flush_s    = run_s && ex_branch_taken;
    stall_s    = run_s && load_use_s && !ex_branch_taken;

    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b1;
    ctrl_action   = ACT_HOLD;
    fwd_a_sel     = 2'b00;
    fwd_b_sel     = 2'b00;
    fwd_c_sel     = 2'b00;

    case (state_q)
      ST_RUN: begin
        fwd_a_sel = fwd_pick(id_rn, id_use_rn, ex_q, mem_q, wb_q);
        fwd_b_sel = fwd_pick(id_rm, id_use_rm, ex_q, mem_q, wb_q);
        fwd_c_sel = fwd_pick(id_rs, id_use_rs, ex_q, mem_q, wb_q);
        if (flush_s) begin
          pc_enable     = 1'b1;
          if_id_enable  = 1'b1;
          if_id_flush   = 1'b1;
          cu_mux_select = 1'b1;
          ctrl_action   = ACT_FLUSH;
        end else if (stall_s) begin
          pc_enable     = 1'b0;
          if_id_enable  = 1'b0;
          if_id_flush   = 1'b0;
          cu_mux_select = 1'b1;
          ctrl_action   = ACT_STALL;
        end else begin
          pc_enable     = 1'b1;
          if_id_enable  = 1'b1;
          if_id_flush   = 1'b0;
          cu_mux_select = 1'b0;
          ctrl_action   = ACT_RUN;
        end
      end
      default: begin
        ctrl_action = ACT_HOLD;
      end
    endcase
  end

  // Next-state: hold countdown, shadow tag advance, saturating counters
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q != HC_W'(0)) begin
          hold_cnt_d = hold_cnt_q - HC_W'(1);
        end else begin
          hold_cnt_d = hold_cnt_q;
        end
        if (hold_cnt_q <= HC_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (cu_mux_select) begin
      ex_d = '{tag: 4'd0, we: 1'b0, ld: 1'b0};
    end else begin
      ex_d = '{tag: id_dest, we: id_reg_write, ld: id_load};
    end

    stall_cnt_d = sat_inc(stall_cnt_q, stall_s);
    flush_cnt_d = sat_inc(flush_cnt_q, flush_s);
  end

  // State, shadow pipeline and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= HOLD_INIT;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed vectors push hand-computed expectations, a monitor
// pops and compares one entry per cycle away from the active edge.
module tb_pipeline_hazard_controller;

  logic       clk;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rs, id_dest;
  logic       id_use_rn, id_use_rm, id_use_rs;
  logic       id_reg_write, id_load, ex_branch_taken;
  logic       pc_enable, if_id_enable, if_id_flush, cu_mux_select;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_c_sel, ctrl_action;
  logic [1:0] stall_count, flush_count;

  typedef struct {
    logic [15:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_hazard_controller #(.RESET_HOLD_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .id_dest(id_dest), .id_reg_write(id_reg_write), .id_load(id_load),
    .ex_branch_taken(ex_branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .cu_mux_select(cu_mux_select),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_c_sel(fwd_c_sel),
    .stall_count(stall_count), .flush_count(flush_count), .ctrl_action(ctrl_action)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the expected outputs.
  // um = {use_rn, use_rm, use_rs}; act selects the fixed control pattern.
  task automatic go(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rs,
                    input logic [2:0] um, input logic [3:0] dest, input logic we,
                    input logic ld, input logic br, input logic rst,
                    input logic [1:0] act, input logic [1:0] fa, input logic [1:0] fb,
                    input logic [1:0] fc, input logic [1:0] sc, input logic [1:0] fcn,
                    input string nm);
    logic [3:0] ctl;
    exp_t e;
    @(negedge clk);
    id_rn = rn; id_rm = rm; id_rs = rs;
    id_use_rn = um[2]; id_use_rm = um[1]; id_use_rs = um[0];
    id_dest = dest; id_reg_write = we; id_load = ld;
    ex_branch_taken = br; reset = rst;
    case (act)
      2'b00:   ctl = 4'b0001;
      2'b01:   ctl = 4'b1100;
      2'b10:   ctl = 4'b0001;
      2'b11:   ctl = 4'b1111;
      default: ctl = 4'b0000;
    endcase
    e.v  = {act, ctl, fa, fb, fc, sc, fcn};
    e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare the presented outputs against the oldest queued expectation
  initial begin
    exp_t e;
    logic [15:0] act_v;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act_v = {ctrl_action, pc_enable, if_id_enable, if_id_flush, cu_mux_select,
                 fwd_a_sel, fwd_b_sel, fwd_c_sel, stall_count, flush_count};
        n_tests++;
        if (act_v !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (act,pc,en,fl,cu,fa,fb,fc,sc,fc)",
                   e.nm, act_v, e.v);
        end
      end
    end
  end

  initial begin
    logic [1:0] sc;
    reset = 1'b1; id_rn = 4'd0; id_rm = 4'd0; id_rs = 4'd0; id_dest = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rs = 1'b0;
    id_reg_write = 1'b0; id_load = 1'b0; ex_branch_taken = 1'b0;

    // reset held for three edges, then two HOLD cycles (branch and writes ignored)
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "rst1");
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "rst2");
    go(4'd8, 4'd0, 4'd0, 3'b100, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "hold1");
    go(4'd8, 4'd0, 4'd0, 3'b100, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "hold2");
    // first RUN cycle: R8 from HOLD was bubbled, so no forward; ADD R5 issues
    go(4'd8, 4'd0, 4'd0, 3'b100, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "run_first");
    go(4'd5, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'd0, 2'd0, "fwd_a_ex");
    go(4'd5, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 2'd0, 2'd0, "fwd_a_mem");
    go(4'd5, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 2'd0, 2'd0, "fwd_a_wb");
    go(4'd5, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "fwd_a_rf");
    // two back-to-back writers of R6: youngest wins; unused rn=R6 stays 00
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "r6_w1");
    go(4'd0, 4'd6, 4'd0, 3'b010, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b00, 2'd0, 2'd0, "r6_w2");
    go(4'd6, 4'd6, 4'd6, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'd0, 2'd0, "prio_ex");
    go(4'd6, 4'd6, 4'd6, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b10, 2'd0, 2'd0, "prio_mem");
    go(4'd6, 4'd6, 4'd6, 3'b011, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b11, 2'b11, 2'd0, 2'd0, "prio_wb");
    // LDRB R2 then use in rm: one stall, then MEM forward
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "ldrb");
    go(4'd0, 4'd2, 4'd0, 3'b010, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "load_use_stall");
    go(4'd0, 4'd2, 4'd0, 3'b010, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b10, 2'b00, 2'd1, 2'd0, "after_stall");
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd0, "idle1");
    // taken branch squashes the ID writer of R9
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'd1, 2'd0, "flush");
    go(4'd9, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd1, "squashed_no_fwd");
    // branch coincident with load-use: flush only
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd1, "ldr_r3");
    go(4'd3, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'd1, 2'd1, "flush_over_stall");
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd2, "counts_after_fos");
    // R15 as load destination never stalls or forwards
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd2, "ld_r15");
    go(4'd15, 4'd15, 4'd0, 3'b110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd2, "r15_no_stall");
    go(4'd15, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd1, 2'd2, "r15_no_fwd_mem");
    // five more load-use stalls on rs: 2-bit counter saturates at 3
    sc = 2'd1;
    for (int i = 0; i < 5; i++) begin
      go(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, sc, 2'd2, "sat_ld");
      go(4'd0, 4'd0, 4'd4, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00,
         (i == 0) ? 2'b00 : 2'b11, sc, 2'd2, "sat_stall");
      sc = (i == 0) ? 2'd2 : 2'd3;
    end
    // reset asserted during a stall cycle
    go(4'd0, 4'd0, 4'd0, 3'b000, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd3, 2'd2, "pre_rst_ld");
    go(4'd0, 4'd0, 4'd4, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b00, 2'b11, 2'd3, 2'd2, "stall_with_rst");
    go(4'd4, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "post_rst_hold1");
    go(4'd4, 4'd0, 4'd0, 3'b100, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "post_rst_hold2");
    go(4'd0, 4'd0, 4'd4, 3'b001, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'd0, 2'd0, "post_rst_run");

    repeat (2) @(negedge clk);
    #4;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued entries, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencer for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB). It drives the PC enable, the IF/ID enable and flush, and the CU-mux bubble select (the hazard bit). It resolves load-use stalls and taken-branch flushes, and generates operand-forwarding selects. It keeps its own shadow pipeline of destination tags for EX, MEM and WB, holds the front end idle for a fixed number of cycles after reset, and keeps saturating stall and flush counters.

Parameters:
RESET_HOLD_CYCLES, 2, cycles after reset release during which the front end is held and bubbles are injected (must be ≥1).
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
id_rn  input  4  ID-stage first source register.
id_rm  input  4  ID-stage second source register.
id_rs  input  4  ID-stage third source (store data / shift register).
id_use_rn, id_use_rm, id_use_rs  input  1 each  the corresponding source is actually read.
id_dest  input  4  ID-stage destination register.
id_reg_write  input  1  ID instruction writes id_dest.
id_load  input  1  ID instruction is a load (LDR/LDRB).
ex_branch_taken  input  1  branch resolved taken in EX this cycle.
pc_enable  output  1  PC register enable.
if_id_enable  output  1  IF/ID register enable.
if_id_flush  output  1  clears IF/ID to NOP on the next edge.
cu_mux_select  output  1  1 = CU mux outputs all-zero control (bubble).
fwd_a_sel, fwd_b_sel, fwd_c_sel  output  2 each  operand source for rn/rm/rs: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
stall_count  output  CNT_W  load-use stalls taken.
flush_count  output  CNT_W  branch flushes taken.
ctrl_action  output  2  action this cycle: 00 HOLD, 01 RUN, 10 STALL, 11 FLUSH.

Behaviour:
- Registered FSM with states HOLD and RUN. Reset forces HOLD, loads hold_cnt = RESET_HOLD_CYCLES, clears shadow tags and both counters.
- HOLD:
  - hold_cnt decrements each cycle; the state moves to RUN on the edge where hold_cnt = 1.
  - Outputs: pc_enable=0, if_id_enable=0, cu_mux_select=1, if_id_flush=0, fwd_*=00, ctrl_action=00.
  - ex_branch_taken is ignored.
- Shadow pipeline (registered each cycle):
  - EX ← {id_dest, id_reg_write, id_load}, or a bubble (we=0, ld=0) when cu_mux_select=1.
  - MEM ← EX; WB ← MEM.
  - Reset clears all shadow valid bits.
- RUN actions are combinational from the state, the shadow tags and the inputs. Priority: FLUSH > STALL > normal.
  - FLUSH, when ex_branch_taken=1:
    - pc_enable=1 (external mux loads the target), if_id_enable=1, if_id_flush=1, cu_mux_select=1.
    - flush_count increments.
  - STALL, when EX.ld & EX.we and EX.tag equals any used ID source:
    - pc_enable=0, if_id_enable=0, cu_mux_select=1, if_id_flush=0.
    - stall_count increments. Exactly one cycle per load-use pair, because the next cycle the load sits in MEM and forwards.
  - Normal: pc_enable=1, if_id_enable=1, cu_mux_select=0, if_id_flush=0.
- Forwarding, per source, in RUN:
  - If the source is unused or is R15, the select is 00.
  - Otherwise pick the youngest matching stage with we=1: EX (01), then MEM (10), then WB (11), else 00.
  - The EX match is valid only when EX.ld=0 (the load case stalls instead).
  - Forwarding selects are still computed during STALL and FLUSH.
- id_dest = R15 with reg_write never causes a stall or forward match.
- Counters saturate at all-ones and never wrap.
- A taken branch coinciding with a load-use hazard counts as FLUSH only; stall_count is unchanged.
- Reset asserted mid-STALL or mid-FLUSH: the next cycle is HOLD with all outputs as in HOLD, and both counters are 0.
- Latency: control outputs are combinational in the same cycle as the inputs; shadow and counter updates take effect on the next edge.

Test Plan:
- Reset high 3 cycles then low, RESET_HOLD_CYCLES=2 -> ctrl_action=00, pc_enable=0 and cu_mux_select=1 for 2 cycles after release; then ctrl_action=01, pc_enable=1; counters 0.
- ADD dest R5 (reg_write=1), then the next ID has id_rn=R5 used -> fwd_a_sel=01. Hold that same ID instruction on the following two cycles -> fwd_a_sel=10, then 11, then 00.
- LDRB dest R2 (load=1), then ID has id_rm=R2 used -> one cycle with pc_enable=0, if_id_enable=0, cu_mux_select=1, ctrl_action=10; stall_count=1 after the edge. Next cycle fwd_b_sel=10, pc_enable=1.
- ex_branch_taken=1 in RUN -> if_id_flush=1, cu_mux_select=1, pc_enable=1, ctrl_action=11; flush_count=1. Next cycle an ID source equal to the squashed dest gives fwd=00.
- ex_branch_taken=1 in the same cycle as a load-use hazard -> ctrl_action=11, flush_count+1, stall_count unchanged. id_dest=R15 followed by id_rn=R15 -> fwd_a_sel=00, no stall.
- CNT_W=2, 5 load-use stalls -> stall_count stays at 3. Assert reset during a stall -> next cycle ctrl_action=00, stall_count=0, flush_count=0.
